// File: rtl/cb_seg_stream.sv
// ---------------------------------------------------------------------------
// cb_seg_stream
//
// Flow-controlled code-block segmentation. One descriptor per transport
// block selects C code blocks (C- of size K-, the rest K+). Block 0 starts
// with F zero filler bytes. When C>1 every block ends with a CRC24B
// (g = 0x800063, init 0, MSB first) computed over its filler and payload.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   desc_*            segmentation descriptor, valid/ready handshake
//   in_data/valid/ready   transport-block byte stream
//   out_data/valid/ready  code-block byte stream (single register stage)
//   out_start/last    first/last byte of a code block
//   out_fill/crc      byte is filler / CRC24B
//   out_size_sel      1 = current block is K+, 0 = K-
//   cb_count          completed code blocks, only with CB_SEG_STATS_EN
//
// Build option: define CB_SEG_STATS_EN to add the cb_count output.
// ---------------------------------------------------------------------------
module cb_seg_stream #(
    parameter int KB_W = 11,
    parameter int C_W  = 6,
    parameter int F_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            desc_valid,
    output logic            desc_ready,
    input  logic [C_W-1:0]  desc_c,
    input  logic [C_W-1:0]  desc_cminus,
    input  logic [KB_W-1:0] desc_kplus,
    input  logic [KB_W-1:0] desc_kminus,
    input  logic [F_W-1:0]  desc_f,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_start,
    output logic            out_last,
    output logic            out_fill,
    output logic            out_crc,
    output logic            out_size_sel
`ifdef CB_SEG_STATS_EN
    ,
    output logic [15:0]     cb_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DATA,
        S_CRC
    } state_e;

    localparam logic [23:0] CRC24B_POLY = 24'h800063;

    // One byte of CRC24B, MSB of the byte first.
    function automatic logic [23:0] crc24b_byte(input logic [23:0] crc,
                                                input logic [7:0]  d);
        logic [23:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[23] ^ d[i]) c = {c[22:0], 1'b0} ^ CRC24B_POLY;
            else              c = {c[22:0], 1'b0};
        end
        return c;
    endfunction

    state_e          state_q;
    logic [C_W-1:0]  c_q;
    logic [C_W-1:0]  cminus_q;
    logic [KB_W-1:0] kplus_q;
    logic [KB_W-1:0] kminus_q;
    logic [F_W-1:0]  f_q;
    logic [C_W-1:0]  r_q;      // current block index
    logic [KB_W-1:0] cnt_q;    // byte index inside the current phase
    logic [23:0]     crc_q;
    logic            first_q;  // next emitted byte opens a block

    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            out_start_q;
    logic            out_last_q;
    logic            out_fill_q;
    logic            out_crc_q;
    logic            out_size_sel_q;

    // Derived per-block quantities, all from registered descriptor state.
    logic            slot_free;
    logic            in_fire;
    logic            size_sel_d;
    logic            multi_cb;
    logic [KB_W-1:0] k_cur;
    logic [KB_W-1:0] fill_sub;
    logic [KB_W-1:0] crc_sub;
    logic [KB_W-1:0] p_cur;
    logic            fill_done;
    logic            data_done;
    logic            crc_done;
    logic            last_blk;
    logic [23:0]     crc_fill_d;
    logic [23:0]     crc_data_d;
    logic [7:0]      crc_byte_d;

    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = (state_q == S_DATA) && slot_free;
    assign in_fire    = in_valid && in_ready;
    assign desc_ready = (state_q == S_IDLE);

    assign size_sel_d = (r_q >= cminus_q);
    assign multi_cb   = (c_q > C_W'(1));
    assign k_cur      = size_sel_d ? kplus_q : kminus_q;
    assign fill_sub   = (r_q == '0) ? KB_W'(f_q) : '0;
    assign crc_sub    = multi_cb ? KB_W'(3) : '0;
    assign p_cur      = k_cur - fill_sub - crc_sub;

    assign fill_done  = (cnt_q == KB_W'(f_q) - KB_W'(1));
    assign data_done  = (cnt_q == p_cur - KB_W'(1));
    assign crc_done   = (cnt_q == KB_W'(2));
    assign last_blk   = (r_q == c_q - C_W'(1));

    assign crc_fill_d = crc24b_byte(crc_q, 8'h00);
    assign crc_data_d = crc24b_byte(crc_q, in_data);

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        crc_byte_d = crc_q[7:0];
        case (cnt_q[1:0])
            2'd0:    crc_byte_d = crc_q[23:16];
            2'd1:    crc_byte_d = crc_q[15:8];
            default: crc_byte_d = crc_q[7:0];
        endcase
    end

    // Control FSM and output register. A byte is produced only when the
    // output slot is free, so the register holds steady under back-pressure.
    // NOTE: state is updated with non-blocking assignments only; later
    // assignments in the same cycle deliberately override earlier ones
    // (e.g. CRC clear at end of block wins over the CRC update).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            c_q            <= '0;
            cminus_q       <= '0;
            kplus_q        <= '0;
            kminus_q       <= '0;
            f_q            <= '0;
            r_q            <= '0;
            cnt_q          <= '0;
            crc_q          <= '0;
            first_q        <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_start_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_fill_q     <= 1'b0;
            out_crc_q      <= 1'b0;
            out_size_sel_q <= 1'b0;
        end else begin
            // Slot drained with nothing new to load: present an empty beat.
            if (slot_free) begin
                out_valid_q    <= 1'b0;
                out_data_q     <= '0;
                out_start_q    <= 1'b0;
                out_last_q     <= 1'b0;
                out_fill_q     <= 1'b0;
                out_crc_q      <= 1'b0;
                out_size_sel_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (desc_valid) begin
                        c_q      <= desc_c;
                        cminus_q <= desc_cminus;
                        kplus_q  <= desc_kplus;
                        kminus_q <= desc_kminus;
                        f_q      <= desc_f;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        crc_q    <= '0;
                        first_q  <= 1'b1;
                        state_q  <= (desc_f != '0) ? S_FILL : S_DATA;
                    end
                end

                S_FILL: begin
                    if (slot_free) begin
                        out_valid_q    <= 1'b1;
                        out_data_q     <= 8'h00;
                        out_start_q    <= first_q;
                        out_fill_q     <= 1'b1;
                        out_size_sel_q <= size_sel_d;
                        crc_q          <= crc_fill_d;
                        first_q        <= 1'b0;
                        if (fill_done) begin
                            cnt_q   <= '0;
                            state_q <= S_DATA;
                        end else begin
                            cnt_q <= cnt_q + KB_W'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (in_fire) begin
                        out_valid_q    <= 1'b1;
                        out_data_q     <= in_data;
                        out_start_q    <= first_q;
                        out_last_q     <= data_done && !multi_cb;
                        out_size_sel_q <= size_sel_d;
                        crc_q          <= crc_data_d;
                        first_q        <= 1'b0;
                        if (data_done) begin
                            cnt_q <= '0;
                            if (multi_cb) begin
                                state_q <= S_CRC;
                            end else begin
                                // End of block (single-block TB is always last).
                                if (last_blk) begin
                                    state_q <= S_IDLE;
                                end else begin
                                    r_q     <= r_q + C_W'(1);
                                    state_q <= S_DATA;
                                end
                                crc_q   <= '0;
                                first_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + KB_W'(1);
                        end
                    end
                end

                S_CRC: begin
                    if (slot_free) begin
                        out_valid_q    <= 1'b1;
                        out_data_q     <= crc_byte_d;
                        out_last_q     <= crc_done;
                        out_crc_q      <= 1'b1;
                        out_size_sel_q <= size_sel_d;
                        if (crc_done) begin
                            cnt_q <= '0;
                            if (last_blk) begin
                                state_q <= S_IDLE;
                            end else begin
                                r_q     <= r_q + C_W'(1);
                                state_q <= S_DATA;
                            end
                            crc_q   <= '0;
                            first_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + KB_W'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_start    = out_start_q;
    assign out_last     = out_last_q;
    assign out_fill     = out_fill_q;
    assign out_crc      = out_crc_q;
    assign out_size_sel = out_size_sel_q;

`ifdef CB_SEG_STATS_EN
    logic [15:0] cb_count_q;

    // Completed blocks: last byte handed over downstream. Wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cb_count_q <= '0;
        end else if (out_valid_q && out_ready && out_last_q) begin
            cb_count_q <= cb_count_q + 16'd1;
        end
    end

    assign cb_count = cb_count_q;
`endif

endmodule
